// File: rtl/hpdcache_binary_to_1hot_buf.sv
// Buffered binary-to-one-hot decoder: decodes on push into a 2-entry FIFO and
// presents the head entry from registers, flagging indexes >= N as errors.
module hpdcache_binary_to_1hot_buf #(
    parameter int N = 4,
    localparam int Log2N = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Log2N-1:0] val_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [N-1:0]     val_o,
    output logic             err_o
);

    logic [N-1:0] mem_val [2];
    logic         mem_err [2];
    logic         rptr;
    logic         wptr;
    logic [1:0]   count;

    logic         push;
    logic         pop;
    logic [31:0]  idx_ext;
    logic [N-1:0] dec_p0;
    logic         err_p0;

    logic         rptr_nxt;
    logic [1:0]   count_nxt;
    logic [N-1:0] head_val_nxt;
    logic         head_err_nxt;

    assign ready_o = (count != 2'd2) && !rst_i;
    assign valid_o = (count != 2'd0) && !rst_i;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    // Stage p0: decode the incoming index before it is stored
    always_comb begin
        idx_ext = 32'(val_i);
        err_p0  = (idx_ext >= 32'(N));
        dec_p0  = '0;
        for (int i = 0; i < N; i++) begin
            dec_p0[i] = (idx_ext == 32'(i));
        end
    end

    // The output register is loaded with the next head; a push into an empty
    // (or just-drained) slot is the new head, otherwise the stored entry is.
    always_comb begin
        rptr_nxt     = pop ? ~rptr : rptr;
        count_nxt    = count + {1'b0, push} - {1'b0, pop};
        head_val_nxt = val_o;
        head_err_nxt = err_o;
        if (count_nxt != 2'd0) begin
            if (push && (rptr_nxt == wptr)) begin
                head_val_nxt = dec_p0;
                head_err_nxt = err_p0;
            end else begin
                head_val_nxt = mem_val[rptr_nxt];
                head_err_nxt = mem_err[rptr_nxt];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= 2'd0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            val_o <= '0;
            err_o <= 1'b0;
        end else begin
            count <= count_nxt;
            rptr  <= rptr_nxt;
            if (push) begin
                wptr <= ~wptr;
            end
            val_o <= head_val_nxt;
            err_o <= head_err_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_val[wptr] <= dec_p0;
            mem_err[wptr] <= err_p0;
        end
    end

endmodule
